// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if: groups the request/grant signals between the requesting units and the
// round-robin arbiter that owns the shared 8:1 mux select.
//
// Signals:
//   req   [7:0]  request vector, req[i] held high by requester i while it wants/uses the mux
//   grant [7:0]  one-hot grant, all zero when idle
//   sel   [2:0]  mux select, index of the set grant bit
//   busy         high whenever grant != 0
//   lock         owner lock, present only when MUX_ARB_LOCK_EN is defined
//
// Modports:
//   master  requester side (drives req/lock, observes grant/sel/busy)
//   slave   arbiter side
//
// Build option: MUX_ARB_LOCK_EN adds the lock signal.

interface mux_sel_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;

    modport master (output req, output lock, input grant, input sel, input busy);
    modport slave  (input req, input lock, output grant, output sel, output busy);
`else
    modport master (output req, input grant, input sel, input busy);
    modport slave  (input req, output grant, output sel, output busy);
`endif
endinterface

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter sharing one 8:1 single-bit mux among 8 requesters.
// Drives the registered mux select and a registered one-hot grant. While another requester
// is pending, an owner keeps the grant for at most MAX_HOLD consecutive cycles; a sole
// requester holds indefinitely.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mux_sel_arbiter_if.slave: req in; grant, sel, busy out (lock in, optional)
//
// Parameters:
//   MAX_HOLD  cycles an owner keeps the grant under contention (1..255)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Build option: define MUX_ARB_LOCK_EN to add the lock input, which suppresses preemption
// while the owner keeps requesting.

module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    mux_sel_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [7:0]       grant_q, grant_d;
    logic [2:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic [2:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [7:0] cand;
    logic       found;
    logic [2:0] win_idx;
    logic [2:0] idx;
    logic       owner_req;
    logic       at_max;
    logic       lock_hold;

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // The current owner is masked out, so the search only ever picks another requester
    // while in GRANT; in IDLE grant_q is zero and everyone is eligible.
    assign cand      = bus.req & ~grant_q;
    assign owner_req = |(bus.req & grant_q);
    assign at_max    = (hold_q == HoldMax);

    // Round-robin search starting just after the last winner, wrapping 7 -> 0.
    always_comb begin
        found   = 1'b0;
        win_idx = last_q;
        idx     = last_q;
        for (int unsigned i = 1; i <= 8; i++) begin
            idx = last_q + 3'(i);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        last_d  = last_q;
        hold_d  = hold_q;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    grant_d = 8'd1 << win_idx;
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    last_d  = win_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    // Release: hand over directly if anyone else waits, otherwise go idle
                    // with sel left at the previous owner.
                    if (found) begin
                        grant_d = 8'd1 << win_idx;
                        sel_d   = win_idx;
                        last_d  = win_idx;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                    hold_d = '0;
                end else if (found && at_max && !lock_hold) begin
                    grant_d = 8'd1 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    hold_d  = '0;
                end else if (!at_max) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            last_q  <= 3'd7;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;

endmodule
